// File: rtl/pf_ddr4_cmd_lane_pkg.sv
// pf_ddr4_cmd_lane_pkg: shared FSM state type and default parameters for the DDR4 command lane controller
package pf_ddr4_cmd_lane_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, MOVE, WAIT, DONE} dl_state_e;

    localparam int unsigned DEF_NUM_LANES  = 8;
    localparam int unsigned DEF_DELAY_W    = 8;
    localparam int unsigned DEF_LOAD_TAP   = 1;
    localparam int unsigned DEF_MAX_TAP    = 255;
    localparam int unsigned DEF_SETTLE_CYC = 4;
    localparam bit          DEF_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/pf_ddr4_dl_seq.sv
// pf_ddr4_dl_seq: per-lane delay-line tap walker; DL_OOR_SYNC_EN adds a 2-flop out-of-range synchroniser
module pf_ddr4_dl_seq
    import pf_ddr4_cmd_lane_pkg::*;
#(
    parameter int unsigned NUM_LANES  = DEF_NUM_LANES,
    parameter int unsigned DELAY_W    = DEF_DELAY_W,
    parameter int unsigned LOAD_TAP   = DEF_LOAD_TAP,
    parameter int unsigned MAX_TAP    = DEF_MAX_TAP,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
    localparam int unsigned LANE_W    = $clog2(NUM_LANES),
    localparam int unsigned CNT_W     = $clog2(SETTLE_CYC)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 req_valid_i,
    input  logic [LANE_W-1:0]    req_lane_i,
    input  logic [DELAY_W-1:0]   req_tap_i,
    input  logic                 req_load_i,
    input  logic [NUM_LANES-1:0] oor_i,
    input  logic                 err_clr_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [DELAY_W-1:0]   cur_tap_o,
    output logic [NUM_LANES-1:0] move_o,
    output logic [NUM_LANES-1:0] dir_o,
    output logic [NUM_LANES-1:0] load_o,
    output logic [NUM_LANES-1:0] err_o
);

    dl_state_e            state_q, state_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [DELAY_W-1:0]   tgt_q, tgt_d, cur_q, cur_d;
    logic [DELAY_W-1:0]   tap_q [NUM_LANES];
    logic [DELAY_W-1:0]   tap_d [NUM_LANES];
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 dir_q, dir_d;
    logic [NUM_LANES-1:0] err_q, err_d, err_set, oor;
    logic [DELAY_W-1:0]   tap_sel;
    logic                 at_tgt, up, last, clamp, stepping;

`ifdef DL_OOR_SYNC_EN
    logic [NUM_LANES-1:0] oor_s1_q, oor_s2_q;

    if (SETTLE_CYC < 4) begin : g_settle_chk
        $error("SETTLE_CYC must be >= 4 when the out-of-range synchroniser is enabled");
    end

    // two-flop synchroniser for the asynchronous IOD out-of-range flags
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            oor_s1_q <= '0;
            oor_s2_q <= '0;
        end else begin
            oor_s1_q <= oor_i;
            oor_s2_q <= oor_s1_q;
        end
    end

    assign oor = oor_s2_q;
`else
    assign oor = oor_i;
`endif

    assign tap_sel  = tap_q[lane_q];
    assign at_tgt   = tap_sel == tgt_q;
    assign up       = tgt_q > tap_sel;
    assign last     = cnt_q == '0;
    assign clamp    = {1'b0, req_tap_i} > (DELAY_W+1)'(MAX_TAP);
    assign stepping = (state_q == MOVE) && !at_tgt;

    // state register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = req_load_i ? LOAD : MOVE;
            LOAD:    state_d = WAIT;
            MOVE:    state_d = at_tgt ? DONE : WAIT;
            WAIT:    if (last) state_d = oor[lane_q] ? DONE : MOVE;
            default: state_d = IDLE;
        endcase
    end

    // datapath next values: request capture, tap stepping, settle count, sticky errors
    always_comb begin
        lane_d  = lane_q;
        tgt_d   = tgt_q;
        tap_d   = tap_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        cur_d   = cur_q;
        err_set = '0;
        if (state_q == IDLE && req_valid_i) begin
            lane_d              = req_lane_i;
            tgt_d               = clamp ? DELAY_W'(MAX_TAP) : req_tap_i;
            err_set[req_lane_i] = clamp;
        end
        if (state_q == LOAD) begin
            tap_d[lane_q] = DELAY_W'(LOAD_TAP);
            cnt_d         = CNT_W'(SETTLE_CYC - 2);
            dir_d         = 1'b0;
        end
        if (stepping) begin
            tap_d[lane_q] = up ? tap_sel + 1'b1 : tap_sel - 1'b1;
            cnt_d         = CNT_W'(SETTLE_CYC - 2);
            dir_d         = up;
        end
        if (state_q == WAIT) begin
            cnt_d           = cnt_q - 1'b1;
            err_set[lane_q] = last && oor[lane_q];
        end
        if (state_q == DONE) cur_d = tap_sel;
        err_d = (err_q & ~{NUM_LANES{err_clr_i}}) | err_set;
    end

    // datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lane_q <= '0;
            tgt_q  <= '0;
            tap_q  <= '{default: DELAY_W'(LOAD_TAP)};
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            cur_q  <= DELAY_W'(LOAD_TAP);
            err_q  <= '0;
        end else begin
            lane_q <= lane_d;
            tgt_q  <= tgt_d;
            tap_q  <= tap_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            cur_q  <= cur_d;
            err_q  <= err_d;
        end
    end

    // state-decoded outputs; only the selected lane's delay-line bits are ever driven
    always_comb begin
        move_o         = '0;
        dir_o          = '0;
        load_o         = '0;
        move_o[lane_q] = stepping;
        dir_o[lane_q]  = stepping ? up : (state_q == WAIT) && dir_q;
        load_o[lane_q] = state_q == LOAD;
    end

    assign busy_o    = state_q != IDLE;
    assign done_o    = state_q == DONE;
    assign cur_tap_o = cur_q;
    assign err_o     = err_q;

endmodule

// File: rtl/pf_ddr4_cmd_lane_ctrl.sv
// pf_ddr4_cmd_lane_ctrl: multi-lane DDR4 command IOD driver with delay-line sequencer (optional DL_OOR_SYNC_EN)
module pf_ddr4_cmd_lane_ctrl
    import pf_ddr4_cmd_lane_pkg::*;
#(
    parameter int unsigned NUM_LANES  = DEF_NUM_LANES,
    parameter int unsigned DELAY_W    = DEF_DELAY_W,
    parameter int unsigned LOAD_TAP   = DEF_LOAD_TAP,
    parameter int unsigned MAX_TAP    = DEF_MAX_TAP,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
    parameter bit          IDLE_LEVEL = DEF_IDLE_LEVEL,
    localparam int unsigned LANE_W    = $clog2(NUM_LANES)
) (
    input  logic                   FAB_CLK,
    input  logic                   ARST_N,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [4*NUM_LANES-1:0] cmd_data,
    input  logic [3:0]             cmd_oe,
    output logic [4*NUM_LANES-1:0] TX_DATA,
    output logic [4*NUM_LANES-1:0] OE_DATA,
    input  logic                   dl_req_valid,
    output logic                   dl_req_ready,
    input  logic [LANE_W-1:0]      dl_req_lane,
    input  logic [DELAY_W-1:0]     dl_req_tap,
    input  logic                   dl_req_load,
    output logic [NUM_LANES-1:0]   DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]   DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0]   DELAY_LINE_LOAD,
    input  logic [NUM_LANES-1:0]   DELAY_LINE_OUT_OF_RANGE,
    output logic                   dl_busy,
    output logic                   dl_done,
    output logic [DELAY_W-1:0]     dl_cur_tap,
    output logic [NUM_LANES-1:0]   dl_err,
    input  logic                   dl_err_clr
);

    logic [4*NUM_LANES-1:0] tx_q, tx_d, oe_q, oe_d;
    logic                   idle, cmd_acc;

    assign idle         = !dl_busy;
    assign cmd_ready    = idle;
    assign dl_req_ready = idle;
    assign cmd_acc      = cmd_valid && idle;

    // accepted words go out one cycle later; otherwise lanes drive the idle level
    always_comb begin
        tx_d = cmd_acc ? cmd_data : {(4*NUM_LANES){IDLE_LEVEL}};
        oe_d = cmd_acc ? {NUM_LANES{cmd_oe}} : '1;
    end

    // lane output registers
    always_ff @(posedge FAB_CLK) begin
        if (!ARST_N) begin
            tx_q <= {(4*NUM_LANES){IDLE_LEVEL}};
            oe_q <= '0;
        end else begin
            tx_q <= tx_d;
            oe_q <= oe_d;
        end
    end

    assign TX_DATA = tx_q;
    assign OE_DATA = oe_q;

    pf_ddr4_dl_seq #(
        .NUM_LANES  (NUM_LANES),
        .DELAY_W    (DELAY_W),
        .LOAD_TAP   (LOAD_TAP),
        .MAX_TAP    (MAX_TAP),
        .SETTLE_CYC (SETTLE_CYC)
    ) u_seq (
        .clk_i       (FAB_CLK),
        .rst_n_i     (ARST_N),
        .req_valid_i (dl_req_valid),
        .req_lane_i  (dl_req_lane),
        .req_tap_i   (dl_req_tap),
        .req_load_i  (dl_req_load),
        .oor_i       (DELAY_LINE_OUT_OF_RANGE),
        .err_clr_i   (dl_err_clr),
        .busy_o      (dl_busy),
        .done_o      (dl_done),
        .cur_tap_o   (dl_cur_tap),
        .move_o      (DELAY_LINE_MOVE),
        .dir_o       (DELAY_LINE_DIRECTION),
        .load_o      (DELAY_LINE_LOAD),
        .err_o       (dl_err)
    );

endmodule

// File: tb/tb_pf_ddr4_cmd_lane_ctrl.sv
// tb_pf_ddr4_cmd_lane_ctrl: directed self-checking bench for the command lane controller
module tb_pf_ddr4_cmd_lane_ctrl;

    logic        FAB_CLK = 1'b0;
    logic        ARST_N  = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_data  = '0;
    logic [3:0]  cmd_oe    = '0;
    logic        cmd_ready;
    logic [31:0] TX_DATA, OE_DATA;
    logic        dl_req_valid = 1'b0;
    logic        dl_req_ready;
    logic [2:0]  dl_req_lane = '0;
    logic [7:0]  dl_req_tap  = '0;
    logic        dl_req_load = 1'b0;
    logic [7:0]  MOVE0, DIR0, LOAD0, ERR0;
    logic [7:0]  OOR0 = '0;
    logic        busy0, done0, clr0 = 1'b0;
    logic [7:0]  cur0;

    logic        cv1 = 1'b0, rdy1, rv1 = 1'b0, rr1, busy1, done1, clr1 = 1'b0;
    logic [31:0] tx1, oe1;
    logic [2:0]  ln1 = '0;
    logic [8:0]  tap1 = '0, cur1;
    logic [7:0]  mv1, dr1, ld1, err1;
    logic [7:0]  oor1 = '0;

    int pass_n = 0, total_n = 0;
    int nmv, nld, nup, ndir, gapbad, stray, rdy, txbad;
    bit to;

    always #5 FAB_CLK = ~FAB_CLK;

    pf_ddr4_cmd_lane_ctrl u0 (
        .FAB_CLK(FAB_CLK), .ARST_N(ARST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_oe(cmd_oe),
        .TX_DATA(TX_DATA), .OE_DATA(OE_DATA),
        .dl_req_valid(dl_req_valid), .dl_req_ready(dl_req_ready), .dl_req_lane(dl_req_lane),
        .dl_req_tap(dl_req_tap), .dl_req_load(dl_req_load),
        .DELAY_LINE_MOVE(MOVE0), .DELAY_LINE_DIRECTION(DIR0), .DELAY_LINE_LOAD(LOAD0),
        .DELAY_LINE_OUT_OF_RANGE(OOR0),
        .dl_busy(busy0), .dl_done(done0), .dl_cur_tap(cur0), .dl_err(ERR0), .dl_err_clr(clr0)
    );

    pf_ddr4_cmd_lane_ctrl #(.DELAY_W(9)) u1 (
        .FAB_CLK(FAB_CLK), .ARST_N(ARST_N),
        .cmd_valid(cv1), .cmd_ready(rdy1), .cmd_data(32'h0), .cmd_oe(4'h0),
        .TX_DATA(tx1), .OE_DATA(oe1),
        .dl_req_valid(rv1), .dl_req_ready(rr1), .dl_req_lane(ln1),
        .dl_req_tap(tap1), .dl_req_load(1'b0),
        .DELAY_LINE_MOVE(mv1), .DELAY_LINE_DIRECTION(dr1), .DELAY_LINE_LOAD(ld1),
        .DELAY_LINE_OUT_OF_RANGE(oor1),
        .dl_busy(busy1), .dl_done(done1), .dl_cur_tap(cur1), .dl_err(err1), .dl_err_clr(clr1)
    );

    task automatic step();
        @(posedge FAB_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // walk u0 cycle by cycle until dl_done, tallying pulses on lane ln; raises OOR after move oor_at
    task automatic run_dl(input int ln, input int oor_at);
        int last;
        logic [7:0] msk;
        msk = 8'(1) << ln;
        nmv = 0; nld = 0; nup = 0; ndir = 0; gapbad = 0; stray = 0; rdy = 0; txbad = 0;
        to = 1'b1;
        last = -1;
        for (int c = 0; c < 3000; c++) begin
            if (MOVE0[ln]) begin
                nmv++;
                if (DIR0[ln]) nup++;
                if (last >= 0 && c - last != 4) gapbad++;
                last = c;
                if (nmv == oor_at) OOR0[ln] = 1'b1;
            end
            if (DIR0[ln]) ndir++;
            if (LOAD0[ln]) nld++;
            if (|((MOVE0 | DIR0 | LOAD0) & ~msk)) stray++;
            if (cmd_ready || dl_req_ready) rdy++;
            if (c > 0 && TX_DATA !== 32'hFFFF_FFFF) txbad++;
            if (done0) begin
                to = 1'b0;
                break;
            end
            step();
        end
    endtask

    initial begin
        int n1;
        bit to1;
        // reset values
        step();
        step();
        chk("rst_tx", TX_DATA, 32'hFFFF_FFFF);
        chk("rst_oe", OE_DATA, 32'h0);
        chk("rst_dl", {MOVE0, DIR0, LOAD0}, 24'h0);
        chk("rst_busy_done", {busy0, done0}, 2'b00);
        chk("rst_err", ERR0, 8'h0);
        chk("rst_cur", cur0, 8'd1);
        chk("rst_ready", {cmd_ready, dl_req_ready}, 2'b11);
        ARST_N = 1'b1;
        step();
        chk("idle_oe", OE_DATA, 32'hFFFF_FFFF);
        chk("idle_tx", TX_DATA, 32'hFFFF_FFFF);

        // single command word, latency 1, then back to idle
        cmd_valid = 1'b1; cmd_data = 32'h1234_56A5; cmd_oe = 4'hF;
        step();
        cmd_valid = 1'b0;
        chk("cmd_tx", TX_DATA, 32'h1234_56A5);
        chk("cmd_oe", OE_DATA, 32'hFFFF_FFFF);
        step();
        chk("cmd_idle_tx", TX_DATA, 32'hFFFF_FFFF);

        // load + walk up lane 3 to tap 5, with a simultaneous command that then stalls
        cmd_valid = 1'b1; cmd_data = 32'hDEAD_BEEF; cmd_oe = 4'h3;
        dl_req_valid = 1'b1; dl_req_lane = 3'd3; dl_req_tap = 8'd5; dl_req_load = 1'b1;
        step();
        dl_req_valid = 1'b0;
        chk("both_tx", TX_DATA, 32'hDEAD_BEEF);
        chk("both_oe", OE_DATA, 32'h3333_3333);
        run_dl(3, 0);
        chk("up_timeout", to, 1'b0);
        chk("up_moves", nmv, 4);
        chk("up_dir_moves", nup, 4);
        chk("up_dir_cycles", ndir, 16);
        chk("up_loads", nld, 1);
        chk("up_gap", gapbad, 0);
        chk("up_stray", stray, 0);
        chk("up_ready_low", rdy, 0);
        chk("up_tx_idle", txbad, 0);
        step();
        chk("up_done_1cyc", done0, 1'b0);
        chk("up_cur", cur0, 8'd5);
        chk("up_idle", {busy0, cmd_ready}, 2'b01);
        step();
        cmd_valid = 1'b0;
        chk("stalled_cmd_tx", TX_DATA, 32'hDEAD_BEEF);

        // walk lane 3 down from 5 to 2 without load
        dl_req_valid = 1'b1; dl_req_tap = 8'd2; dl_req_load = 1'b0;
        step();
        dl_req_valid = 1'b0;
        run_dl(3, 0);
        chk("dn_timeout", to, 1'b0);
        chk("dn_moves", nmv, 3);
        chk("dn_dir", nup + ndir, 0);
        chk("dn_loads", nld, 0);
        chk("dn_gap", gapbad, 0);
        step();
        chk("dn_cur", cur0, 8'd2);

        // out-of-range raised after the 2nd move aborts the walk
        dl_req_valid = 1'b1; dl_req_tap = 8'd10; dl_req_load = 1'b1;
        step();
        dl_req_valid = 1'b0;
        run_dl(3, 2);
        chk("oor_timeout", to, 1'b0);
        chk("oor_moves", nmv, 2);
        chk("oor_dir_cycles", ndir, 8);
        chk("oor_err_set", ERR0, 8'h08);
        step();
        OOR0 = '0;
        chk("oor_cur", cur0, 8'd3);
        chk("oor_err_sticky", ERR0, 8'h08);
        clr0 = 1'b1;
        step();
        clr0 = 1'b0;
        chk("err_clr", ERR0, 8'h00);

        // target above MAX_TAP on 9-bit instance: clamp, err at accept (set beats clear)
        rv1 = 1'b1; ln1 = 3'd0; tap1 = 9'd300; clr1 = 1'b1;
        step();
        rv1 = 1'b0; clr1 = 1'b0;
        chk("clamp_err", err1, 8'h01);
        n1 = 0;
        to1 = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if (mv1[0]) n1++;
            if (done1) begin
                to1 = 1'b0;
                break;
            end
            step();
        end
        chk("clamp_timeout", to1, 1'b0);
        chk("clamp_moves", n1, 254);
        step();
        chk("clamp_cur", cur1, 9'd255);

        // reset in the middle of a WAIT abandons the walk
        dl_req_valid = 1'b1; dl_req_lane = 3'd1; dl_req_tap = 8'd9; dl_req_load = 1'b0;
        step();
        dl_req_valid = 1'b0;
        chk("mid_move", {MOVE0, DIR0}, 16'h0202);
        step();
        chk("mid_wait_busy", busy0, 1'b1);
        ARST_N = 1'b0;
        step();
        chk("mid_rst_dl", {MOVE0, DIR0, LOAD0}, 24'h0);
        chk("mid_rst_state", {busy0, done0}, 2'b00);
        chk("mid_rst_out", {TX_DATA, OE_DATA}, 64'hFFFF_FFFF_0000_0000);
        chk("mid_rst_cur", cur0, 8'd1);
        chk("mid_rst_err1", err1, 8'h00);
        ARST_N = 1'b1;
        n1 = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (|MOVE0 || done0) n1++;
        end
        chk("post_rst_quiet", n1, 0);

        // lane 1 tap was reset: request its reset tap, expect immediate done
        dl_req_valid = 1'b1; dl_req_tap = 8'd1;
        step();
        dl_req_valid = 1'b0;
        chk("same_tap_nomove", MOVE0, 8'h00);
        step();
        chk("same_tap_done", done0, 1'b1);
        step();
        chk("same_tap_cur", cur0, 8'd1);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
